bild_ausgabe: RTL and testbench

- VGA scan-out stage: the read-side consumer of the 800×525 8-bit framebuffer.
- Generates 640×480@60 raster timing and drives `x_data`/`y_data` into the framebuffer read port.
- Takes the combinational `pixelData` back and registers it, together with sync and blanking, onto the VGA pins.
- Gives the CPU side `vblank` and `frame_start` so it can schedule drawing.

---
 rtl/bild_ausgabe.sv | 126 ++++++++++++
 tb/tb_bild_ausgabe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bild_ausgabe.sv
// VGA scan-out stage: raster counters drive the framebuffer read port, and the
// returned pixel is registered together with sync, blanking and frame markers.
module bild_ausgabe #(
  parameter int CLK_DIV   = 1,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  input  logic [7:0]  pixelData,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        de,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [3:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, vb_q, vb_d, fs_q, fs_d;
  logic             pix_en_s, h_wrap_s, v_wrap_s, vis_s;

  // next-state for divider, raster counters and output stage
  always_comb begin
    pix_en_s = (div_q == DIV_LAST);
    h_wrap_s = (h_q == H_LAST);
    v_wrap_s = (v_q == V_LAST);
    vis_s    = (h_q < H_VIS) && (v_q < V_VIS);
    div_d = pix_en_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    h_d  = h_q;
    v_d  = v_q;
    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    vb_d = vb_q;
    fs_d = pix_en_s && h_wrap_s && v_wrap_s;
    if (pix_en_s) begin
      h_d = h_wrap_s ? 10'd0 : h_q + 10'd1;
      if (h_wrap_s) begin
        v_d = v_wrap_s ? 10'd0 : v_q + 10'd1;
      end else begin
        v_d = v_q;
      end
      // off-screen pixel data is discarded so blanking is truly black
      r_d  = vis_s ? {pixelData[7:5], pixelData[7]}   : 4'd0;
      g_d  = vis_s ? {pixelData[4:2], pixelData[4]}   : 4'd0;
      b_d  = vis_s ? {pixelData[1:0], pixelData[1:0]} : 4'd0;
      hs_d = !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_d = !((v_q >= VS_BEG) && (v_q < VS_END));
      de_d = vis_s;
      vb_d = (v_q >= V_VIS);
    end else begin
      fs_d = 1'b0;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= {DIV_W{1'b0}};
      h_q   <= 10'd0;
      v_q   <= 10'd0;
      r_q   <= 4'd0;
      g_q   <= 4'd0;
      b_q   <= 4'd0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      vb_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      vb_q  <= vb_d;
      fs_q  <= fs_d;
    end
  end

  assign x_data      = {6'd0, h_q};
  assign y_data      = {6'd0, v_q};
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign de          = de_q;
  assign vblank      = vb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_bild_ausgabe.sv
// Bench for bild_ausgabe: two reduced-raster instances (divider 1 and 3) checked
// every cycle against a model derived from the count of cycles since reset.
module tb_bild_ausgabe;

  localparam int HV = 40, HF = 4, HS = 8, HB = 6;
  localparam int VV = 30, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam int DA = 1;
  localparam int DB = 3;

  logic        clk;
  logic        rst;
  logic [7:0]  fb [0:TOT-1];

  logic [15:0] xa, ya, xb, yb;
  logic [7:0]  pa, pb;
  logic [3:0]  ra, ga, ba, rb, gb, bb;
  logic        hsa, vsa, dea, vba, fsa, hsb, vsb, deb, vbb, fsb;

  int n_checks;
  int n_errors;
  int ea, eb, cyc, last_a, last_b;

  function automatic logic [7:0] fb_at(input logic [15:0] x, input logic [15:0] y);
    if (x < 16'(HT) && y < 16'(VT)) return fb[int'(y) * HT + int'(x)];
    return 8'h00;
  endfunction

  assign pa = fb_at(xa, ya);
  assign pb = fb_at(xb, yb);

  bild_ausgabe #(.CLK_DIV(DA), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) u_dut_a (
    .clk(clk), .rst(rst), .x_data(xa), .y_data(ya), .pixelData(pa),
    .vga_r(ra), .vga_g(ga), .vga_b(ba), .vga_hsync(hsa), .vga_vsync(vsa),
    .de(dea), .vblank(vba), .frame_start(fsa));

  bild_ausgabe #(.CLK_DIV(DB), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) u_dut_b (
    .clk(clk), .rst(rst), .x_data(xb), .y_data(yb), .pixelData(pb),
    .vga_r(rb), .vga_g(gb), .vga_b(bb), .vga_hsync(hsb), .vga_vsync(vsb),
    .de(deb), .vblank(vbb), .frame_start(fsb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // e = rising edges with rst high since the last reset edge
  task automatic model_check(input string nm, input int e, input int d,
                             input logic [15:0] xo, input logic [15:0] yo,
                             input logic [3:0] ro, input logic [3:0] go, input logic [3:0] bo,
                             input logic hso, input logic vso, input logic deo,
                             input logic vbo, input logic fso);
    int n, pos, prev, px, py, p, r3, g3, b2;
    int ex, ey, er, eg, eb2, ehs, evs, ede, evb, efs;
    bit vis;
    n = e / d;
    pos = n % TOT;
    ex = pos % HT;
    ey = pos / HT;
    if (n == 0) begin
      er = 0; eg = 0; eb2 = 0; ehs = 1; evs = 1; ede = 0; evb = 0; efs = 0;
    end else begin
      prev = (n - 1) % TOT;
      px = prev % HT;
      py = prev / HT;
      p = int'(fb[prev]);
      vis = (px < HV) && (py < VV);
      r3 = (p >> 5) & 7;
      g3 = (p >> 2) & 7;
      b2 = p & 3;
      er  = vis ? r3 * 2 + (r3 >> 2) : 0;
      eg  = vis ? g3 * 2 + (g3 >> 2) : 0;
      eb2 = vis ? b2 * 5 : 0;
      ehs = (px >= HV + HF && px < HV + HF + HS) ? 0 : 1;
      evs = (py >= VV + VF && py < VV + VF + VS) ? 0 : 1;
      ede = vis ? 1 : 0;
      evb = (py >= VV) ? 1 : 0;
      efs = ((e % d) == 0 && pos == 0) ? 1 : 0;
    end
    chk({nm, "_x"}, 32'(xo), 32'(ex));
    chk({nm, "_y"}, 32'(yo), 32'(ey));
    chk({nm, "_r"}, 32'(ro), 32'(er));
    chk({nm, "_g"}, 32'(go), 32'(eg));
    chk({nm, "_b"}, 32'(bo), 32'(eb2));
    chk({nm, "_hsync"}, 32'(hso), 32'(ehs));
    chk({nm, "_vsync"}, 32'(vso), 32'(evs));
    chk({nm, "_de"}, 32'(deo), 32'(ede));
    chk({nm, "_vblank"}, 32'(vbo), 32'(evb));
    chk({nm, "_frame_start"}, 32'(fso), 32'(efs));
  endtask

  // one clk: advance the model at the edge, compare on the falling edge
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) begin
      ea++;
      eb++;
    end else begin
      ea = 0;
      eb = 0;
      last_a = -1;
      last_b = -1;
    end
    @(negedge clk);
    model_check("A", ea, DA, xa, ya, ra, ga, ba, hsa, vsa, dea, vba, fsa);
    model_check("B", eb, DB, xb, yb, rb, gb, bb, hsb, vsb, deb, vbb, fsb);
    if (fsa) begin
      if (last_a >= 0) chk("A_frame_period", 32'(cyc - last_a), 32'(TOT * DA));
      last_a = cyc;
    end
    if (fsb) begin
      if (last_b >= 0) chk("B_frame_period", 32'(cyc - last_b), 32'(TOT * DB));
      last_b = cyc;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ea = 0;
    eb = 0;
    cyc = 0;
    last_a = -1;
    last_b = -1;
    for (int i = 0; i < TOT; i++) fb[i] = 8'($urandom);
    fb[0]           = 8'hE0;
    fb[5 * HT + 5]  = 8'h1F;
    fb[HV]          = 8'hFF;
    fb[TOT - 1]     = 8'hFF;
    rst = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    repeat (1000 + $urandom_range(0, 500)) step();
    rst = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    repeat (16000) step();
    rst = 1'b0;
    repeat (3 + $urandom_range(0, 4)) step();
    rst = 1'b1;
    repeat (16000 + $urandom_range(0, 100)) step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
